// File: rtl/m_load_ext.sv
// M-stage load-return unit: issues one bus read per accepted load, then aligns and
// extends the returned word; flags misaligned loads (adel) and response timeouts (bus_err).
module m_load_ext #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_req,
    input  logic [31:0] Addr,
    input  logic [2:0]  DMOp,
    input  logic        flush,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rvalid,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic        stall,
    output logic        done,
    output logic [31:0] DataOut,
    output logic        adel,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [1:0]       off;
    logic [2:0]       op;
    logic [CNT_W-1:0] cnt;
    logic             misal, take, accept, reject, timeout;
    logic [7:0]       bsel;
    logic [15:0]      hsel;
    logic [31:0]      ext;

    always_comb begin
        case (DMOp)
            3'd0:       misal = (Addr[1:0] != 2'b00);
            3'd1, 3'd3: misal = Addr[0];
            3'd2, 3'd4: misal = 1'b0;
            default:    misal = 1'b1;
        endcase
    end

    // In the done cycle M still holds the load that just completed, so ld_req is ignored.
    assign take    = ld_req && !flush && !done && (state == IDLE);
    assign accept  = take && !misal;
    assign reject  = take && misal;
    assign timeout = (cnt == CNT_LAST);

    always_comb begin
        case (off)
            2'd0:    bsel = bus_rdata[7:0];
            2'd1:    bsel = bus_rdata[15:8];
            2'd2:    bsel = bus_rdata[23:16];
            default: bsel = bus_rdata[31:24];
        endcase
        hsel = off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (op)
            3'd0:    ext = bus_rdata;
            3'd1:    ext = {{16{hsel[15]}}, hsel};
            3'd2:    ext = {{24{bsel[7]}}, bsel};
            3'd3:    ext = {16'h0000, hsel};
            3'd4:    ext = {24'h000000, bsel};
            default: ext = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = REQ;
            REQ:   state_nxt = flush ? IDLE : WAIT;
            WAIT: begin
                // A flushed response is dropped; only drain if it is still in flight.
                if (flush)           state_nxt = bus_rvalid ? IDLE : DRAIN;
                else if (bus_rvalid) state_nxt = IDLE;
                else if (timeout)    state_nxt = DRAIN;
            end
            DRAIN: if (bus_rvalid || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus_req = (state == REQ) && !flush;
        stall   = (state == REQ) || (state == WAIT) || accept;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done     <= 1'b0;
            adel     <= 1'b0;
            bus_err  <= 1'b0;
            DataOut  <= 32'h0;
            bus_addr <= 32'h0;
            off      <= 2'b00;
            op       <= 3'd0;
            cnt      <= '0;
        end else begin
            done    <= 1'b0;
            adel    <= reject;
            bus_err <= 1'b0;
            if (accept) begin
                off      <= Addr[1:0];
                op       <= DMOp;
                bus_addr <= {Addr[31:2], 2'b00};
            end
            case (state)
                REQ: cnt <= '0;
                WAIT: begin
                    if (flush) begin
                        cnt <= '0;
                    end else if (bus_rvalid) begin
                        DataOut <= ext;
                        done    <= 1'b1;
                    end else if (timeout) begin
                        DataOut <= 32'h0;
                        bus_err <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule
